// File: rtl/alloc_controller.sv
// ---------------------------------------------------------------------------
// alloc_controller
//
// Sequencing FSM for the dynamic memory allocator. The controller accepts one
// allocate or free request at a time. It scans the six-entry allocation status
// file for a suitable region and reads that region's base from the
// starting-address file. It then updates the status file and the
// register-to-address map.
//
// Build option:
//   ALLOC_BEST_FIT_EN  when defined, an allocate scan starts at the region whose
//                      index equals the size class, so the first eligible region
//                      is the smallest one that fits. When undefined, every scan
//                      starts at region 0 (first fit). A free always starts at 0.
//
// Ports:
//   clk, reset            clock (posedge) and synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op                0 = allocate, 1 = free
//   req_size              bytes requested (1..64), ignored on free
//   req_reg               processor register receiving/holding the address
//   resp_valid            one-cycle completion pulse
//   resp_ok               success flag, valid with resp_valid
//   resp_addr             allocated/freed base, 0 on failure
//   st_rd                 status file read data, region k on [6k+5:6k]
//   st_we/st_a/st_wd      status file write port
//   sa_a/sa_rd            starting-address file index and combinational data
//   r2a_reg/r2a_rd        map index (latched req_reg) and combinational data
//   r2a_we/r2a_wd         map write port
// ---------------------------------------------------------------------------
module alloc_controller #(
    parameter int unsigned NREG = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [6:0]          req_size,
    input  logic [2:0]          req_reg,
    output logic                resp_valid,
    output logic                resp_ok,
    output logic [7:0]          resp_addr,
    input  logic [6*NREG-1:0]   st_rd,
    output logic                st_we,
    output logic [2:0]          st_a,
    output logic [5:0]          st_wd,
    output logic [2:0]          sa_a,
    input  logic [7:0]          sa_rd,
    output logic [2:0]          r2a_reg,
    input  logic [7:0]          r2a_rd,
    output logic                r2a_we,
    output logic [7:0]          r2a_wd
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StScan,
        StWrite,
        StResp
    } state_e;

    localparam logic [5:0] StAllocated = 6'h3F;
    localparam logic [7:0] MapEmpty    = 8'hFF;

    state_e      state_q;
    logic        op_q;
    logic [6:0]  size_q;
    logic [2:0]  reg_q;
    logic [2:0]  cls_q;
    logic [7:0]  target_q;
    logic [2:0]  idx_q;

    logic        dec_err;
    logic [2:0]  dec_cls;
    logic [2:0]  start_idx;
    logic [5:0]  cur_status;
    logic [5:0]  free_mask;
    logic        alloc_hit;
    logic        free_hit;
    logic        hit;
    logic        last_idx;

    // The scan index addresses both files, so the starting-address data seen
    // during SCAN and WRITE always belongs to the region under test.
    assign sa_a    = idx_q;
    assign st_a    = idx_q;
    assign r2a_reg = reg_q;

    // Ready is gated by reset so that it reads 0 while reset is held.
    assign req_ready = (state_q == StIdle) && !reset;

    // Size class: 1-2 -> 0, 3-4 -> 1, 5-8 -> 2, 9-16 -> 3, 17-32 -> 4, 33-64 -> 5.
    always_comb begin
        dec_err = 1'b0;
        dec_cls = 3'd0;
        if (size_q == 7'd0 || size_q > 7'd64) begin
            dec_err = 1'b1;
        end else if (size_q <= 7'd2) begin
            dec_cls = 3'd0;
        end else if (size_q <= 7'd4) begin
            dec_cls = 3'd1;
        end else if (size_q <= 7'd8) begin
            dec_cls = 3'd2;
        end else if (size_q <= 7'd16) begin
            dec_cls = 3'd3;
        end else if (size_q <= 7'd32) begin
            dec_cls = 3'd4;
        end else begin
            dec_cls = 3'd5;
        end
    end

`ifdef ALLOC_BEST_FIT_EN
    // Regions below the class index can never serve it, so skip them.
    assign start_idx = op_q ? 3'd0 : dec_cls;
`else
    assign start_idx = 3'd0;
`endif

    // Select the status word of the region being scanned.
    always_comb begin
        cur_status = StAllocated;
        for (int i = 0; i < int'(NREG); i++) begin
            if (idx_q == 3'(i)) begin
                cur_status = st_rd[6*i +: 6];
            end
        end
    end

    // A free region k serves classes 0..k: bits above k are set.
    assign free_mask = 6'h3F << (idx_q + 3'd1);

    assign alloc_hit = ~cur_status[cls_q];
    assign free_hit  = (cur_status == StAllocated) && (sa_rd == target_q);
    assign hit       = op_q ? free_hit : alloc_hit;
    assign last_idx  = (idx_q == 3'(NREG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= 1'b0;
            size_q     <= 7'd0;
            reg_q      <= 3'd0;
            cls_q      <= 3'd0;
            target_q   <= 8'd0;
            idx_q      <= 3'd0;
            resp_valid <= 1'b0;
            resp_ok    <= 1'b0;
            resp_addr  <= 8'd0;
            st_we      <= 1'b0;
            st_wd      <= 6'd0;
            r2a_we     <= 1'b0;
            r2a_wd     <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        size_q    <= req_size;
                        reg_q     <= req_reg;
                        resp_addr <= 8'd0;
                        resp_ok   <= 1'b0;
                        state_q   <= StDecode;
                    end
                end

                StDecode: begin
                    cls_q    <= dec_cls;
                    target_q <= r2a_rd;
                    idx_q    <= start_idx;
                    if (!op_q && dec_err) begin
                        resp_valid <= 1'b1;
                        resp_ok    <= 1'b0;
                        state_q    <= StResp;
                    end else begin
                        state_q <= StScan;
                    end
                end

                StScan: begin
                    if (hit) begin
                        // Strobes and data are registered here so they are
                        // presented for exactly the WRITE cycle.
                        st_we     <= 1'b1;
                        st_wd     <= op_q ? free_mask : StAllocated;
                        r2a_we    <= 1'b1;
                        r2a_wd    <= op_q ? MapEmpty : sa_rd;
                        resp_addr <= sa_rd;
                        state_q   <= StWrite;
                    end else if (last_idx) begin
                        resp_valid <= 1'b1;
                        resp_ok    <= 1'b0;
                        state_q    <= StResp;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end

                StWrite: begin
                    st_we      <= 1'b0;
                    r2a_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_ok    <= 1'b1;
                    state_q    <= StResp;
                end

                StResp: begin
                    resp_valid <= 1'b0;
                    resp_ok    <= 1'b0;
                    state_q    <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alloc_controller.sv
// ---------------------------------------------------------------------------
// tb_alloc_controller
//
// Directed bench for alloc_controller. The bench holds the three register files
// the controller drives: the status file, the starting-address file (bases
// 0x00, 0x02, 0x06, 0x0E, 0x1E, 0x3E) and the register-to-address map. Every
// expected value below is hand-computed. Define ALLOC_BEST_FIT_EN for both the
// DUT and the bench to select the best-fit timing.
// ---------------------------------------------------------------------------
module tb_alloc_controller;

`ifdef ALLOC_BEST_FIT_EN
    localparam bit BestFit = 1'b1;
`else
    localparam bit BestFit = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [6:0]  req_size;
    logic [2:0]  req_reg;
    logic        resp_valid;
    logic        resp_ok;
    logic [7:0]  resp_addr;
    logic [35:0] st_rd;
    logic        st_we;
    logic [2:0]  st_a;
    logic [5:0]  st_wd;
    logic [2:0]  sa_a;
    logic [7:0]  sa_rd;
    logic [2:0]  r2a_reg;
    logic [7:0]  r2a_rd;
    logic        r2a_we;
    logic [7:0]  r2a_wd;

    logic [5:0]  st_file [6];
    logic [7:0]  map_file [8];
    logic [7:0]  sa_file [8];

    int          st_wr_cnt;
    int          map_wr_cnt;
    int          resp_cnt;
    logic [2:0]  last_st_a;
    logic [5:0]  last_st_wd;

    int          n_checks;
    int          n_fail;

    alloc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_size   (req_size),
        .req_reg    (req_reg),
        .resp_valid (resp_valid),
        .resp_ok    (resp_ok),
        .resp_addr  (resp_addr),
        .st_rd      (st_rd),
        .st_we      (st_we),
        .st_a       (st_a),
        .st_wd      (st_wd),
        .sa_a       (sa_a),
        .sa_rd      (sa_rd),
        .r2a_reg    (r2a_reg),
        .r2a_rd     (r2a_rd),
        .r2a_we     (r2a_we),
        .r2a_wd     (r2a_wd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        sa_file[0] = 8'h00;
        sa_file[1] = 8'h02;
        sa_file[2] = 8'h06;
        sa_file[3] = 8'h0E;
        sa_file[4] = 8'h1E;
        sa_file[5] = 8'h3E;
        sa_file[6] = 8'hF0;
        sa_file[7] = 8'hF0;
    end

    always_comb begin
        st_rd = '0;
        for (int i = 0; i < 6; i++) begin
            st_rd[6*i +: 6] = st_file[i];
        end
    end

    assign sa_rd  = sa_file[sa_a];
    assign r2a_rd = map_file[r2a_reg];

    // Register files and write/response counters.
    initial begin
        st_wr_cnt  = 0;
        map_wr_cnt = 0;
        resp_cnt   = 0;
        last_st_a  = 3'd0;
        last_st_wd = 6'd0;
    end

    always @(posedge clk) begin
        if (reset) begin
            st_file[0] <= 6'h3E;
            st_file[1] <= 6'h3C;
            st_file[2] <= 6'h38;
            st_file[3] <= 6'h30;
            st_file[4] <= 6'h20;
            st_file[5] <= 6'h00;
            for (int i = 0; i < 8; i++) begin
                map_file[i] <= 8'hFF;
            end
        end else begin
            if (st_we) begin
                if (st_a < 3'd6) begin
                    st_file[st_a] <= st_wd;
                end
                st_wr_cnt  <= st_wr_cnt + 1;
                last_st_a  <= st_a;
                last_st_wd <= st_wd;
            end
            if (r2a_we) begin
                map_file[r2a_reg] <= r2a_wd;
                map_wr_cnt        <= map_wr_cnt + 1;
            end
            if (resp_valid) begin
                resp_cnt <= resp_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // One complete request: the accept edge is cycle 0, so the value sampled
    // just after the accept edge belongs to cycle 1.
    task automatic run_req(input string tag, input logic op, input logic [6:0] size,
                           input logic [2:0] rg, input logic exp_ok,
                           input logic [7:0] exp_addr, input int exp_cyc);
        int cyc;
        int st0;
        int mp0;
        check_eq({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_size  = size;
        req_reg   = rg;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        st0 = st_wr_cnt;
        mp0 = map_wr_cnt;
        while (!resp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, ".cycle"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, ".ok"}, 32'(resp_ok), 32'(exp_ok));
        check_eq({tag, ".addr"}, 32'(resp_addr), 32'(exp_addr));
        check_eq({tag, ".st_writes"}, 32'(st_wr_cnt - st0), exp_ok ? 32'd1 : 32'd0);
        check_eq({tag, ".map_writes"}, 32'(map_wr_cnt - mp0), exp_ok ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int s;
        int r0;
        int w0;
        int m0;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_size  = 7'd0;
        req_reg   = 3'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.ready", 32'(req_ready), 32'd0);
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.resp_ok", 32'(resp_ok), 32'd0);
        check_eq("rst.resp_addr", 32'(resp_addr), 32'd0);
        check_eq("rst.st_we", 32'(st_we), 32'd0);
        check_eq("rst.r2a_we", 32'(r2a_we), 32'd0);
        check_eq("rst.r2a_wd", 32'(r2a_wd), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst.ready_after", 32'(req_ready), 32'd1);

        // Allocate 3 bytes into reg 2: class 1, region 1, base 0x02.
        s = BestFit ? 1 : 0;
        run_req("alloc3", 1'b0, 7'd3, 3'd2, 1'b1, 8'h02, 1 - s + 4);
        check_eq("alloc3.st_a", 32'(last_st_a), 32'd1);
        check_eq("alloc3.st_wd", 32'(last_st_wd), 32'h3F);
        check_eq("alloc3.status1", 32'(st_file[1]), 32'h3F);
        check_eq("alloc3.map2", 32'(map_file[2]), 32'h02);

        // Free reg 2, then a double free.
        run_req("free2", 1'b1, 7'd0, 3'd2, 1'b1, 8'h02, 5);
        check_eq("free2.status1", 32'(st_file[1]), 32'h3C);
        check_eq("free2.map2", 32'(map_file[2]), 32'hFF);
        run_req("dfree2", 1'b1, 7'd0, 3'd2, 1'b0, 8'h00, 8);

        // Size 2 into region 0, then size 64 into region 5.
        run_req("alloc2", 1'b0, 7'd2, 3'd1, 1'b1, 8'h00, 4);
        check_eq("alloc2.map1", 32'(map_file[1]), 32'h00);
        run_req("alloc64", 1'b0, 7'd64, 3'd3, 1'b1, 8'h3E, BestFit ? 4 : 9);
        check_eq("alloc64.status5", 32'(st_file[5]), 32'h3F);
        check_eq("alloc64.map3", 32'(map_file[3]), 32'h3E);

        // Size errors.
        run_req("size0", 1'b0, 7'd0, 3'd4, 1'b0, 8'h00, 2);
        run_req("size65", 1'b0, 7'd65, 3'd4, 1'b0, 8'h00, 2);
        check_eq("sizeerr.map4", 32'(map_file[4]), 32'hFF);

        // Fill all six regions with size-2 allocations; the seventh fails.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_req($sformatf("fill%0d", i), 1'b0, 7'd2, 3'(i), 1'b1, sa_file[i], i + 4);
        end
        check_eq("fill.status3", 32'(st_file[3]), 32'h3F);
        check_eq("fill.map5", 32'(map_file[5]), 32'h3E);
        run_req("fill7", 1'b0, 7'd2, 3'd6, 1'b0, 8'h00, 8);

        // Reset in the middle of an allocation scan.
        apply_reset();
        r0 = resp_cnt;
        w0 = st_wr_cnt;
        m0 = map_wr_cnt;
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_size  = 7'd3;
        req_reg   = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst.st_we", 32'(st_we), 32'd0);
        check_eq("midrst.ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("midrst.ready_after", 32'(req_ready), 32'd1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        check_eq("midrst.no_resp", 32'(resp_cnt - r0), 32'd0);
        check_eq("midrst.no_st_write", 32'(st_wr_cnt - w0), 32'd0);
        check_eq("midrst.no_map_write", 32'(map_wr_cnt - m0), 32'd0);
        check_eq("midrst.status1", 32'(st_file[1]), 32'h3C);

        // Back-to-back after an abort still works.
        run_req("post_rst", 1'b0, 7'd5, 3'd0, 1'b1, 8'h06, BestFit ? 4 : 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alloc_controller.md
# alloc_controller

Sequencing FSM for the dynamic memory allocator. It accepts one allocate or free request at a time and picks a region from the six-entry allocation status file. It reads the region base from the starting-address file, then updates the status file and the register-to-address map. It sits between the processor-side request port and those three register files, and it is the only writer of the status file and the map during normal operation.

## Interface
Parameters:
- `NREG`, 6: number of regions/size classes; fixed at 6, not for override.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  1  0 = allocate, 1 = free.
- `req_size`  in  7  bytes requested, 1..64; ignored on free.
- `req_reg`  in  3  processor register that receives or holds the address.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_ok`  out  1  1 = success; valid with `resp_valid`.
- `resp_addr`  out  8  allocated/freed base; 0 when `resp_ok`=0.
- `st_rd`  in  36  status of region k on bits [6k+5:6k].
- `st_we`, `st_a`, `st_wd`  out  1/3/6  status file write port.
- `sa_a`  out  3  starting-address file index.
- `sa_rd`  in  8  base of region `sa_a`, combinational.
- `r2a_reg`  out  3  map index; equals latched `req_reg` while busy.
- `r2a_rd`  in  8  map read data, combinational.
- `r2a_we`, `r2a_wd`  out  1/8  map write port.

## Operation
- **Status encoding:** region k serves class j iff bit j of its status is 0.
  - Free mask for region k: `6'h3F << (k+1)`, truncated to 6 bits.
  - Allocated region = `6'h3F`.
- **Size class:** 1–2→0, 3–4→1, 5–8→2, 9–16→3, 17–32→4, 33–64→5. Size 0 or >64 is an error.
- **States:** IDLE, DECODE, SCAN, WRITE, RESP.
- **IDLE:** `req_ready`=1. When `req_valid`=1, latch op/size/reg and go to DECODE. Requests are not accepted in any other state.
- **DECODE:**
  - Allocate: compute class c; on error go to RESP with ok=0.
  - Free: latch `r2a_rd` as the target address.
  - Scan index k := start (see Configuration).
- **SCAN:** examines one region per cycle with `sa_a`=k.
  - Allocate hit: status[k] bit c = 0.
  - Free hit: status[k]=`6'h3F` and `sa_rd` = target address.
  - Hit → WRITE. Miss at k=5 → RESP with ok=0. Otherwise k+1.
- **WRITE:**
  - `st_we`=1, `st_a`=k, `r2a_we`=1, `sa_a`=k.
  - Allocate: `st_wd`=`6'h3F`, `r2a_wd`=`sa_rd`.
  - Free: `st_wd`=free mask(k), `r2a_wd`=`8'hFF`.
  - Latch `sa_rd` into `resp_addr`.
- **RESP:** `resp_valid`=1 for one cycle, then IDLE.
- **Failure:** a failed request performs no writes.
- **Free:** a free whose address matches no allocated region fails (double free, or a never-allocated register).

## Timing
- Cycle 0 is the accept edge. DECODE is cycle 1 and SCAN starts at cycle 2.
- Allocate with scan start s, hit at region k: WRITE at cycle k−s+3, `resp_valid` at k−s+4.
- Free: same formula with s=0.
- Scan miss: `resp_valid` at cycle 8−s.
- Size error: `resp_valid` at cycle 2.
- Write strobes are asserted for exactly one cycle. The files update at the edge ending WRITE, so the next request sees the new state.
- Reset values: state IDLE, `req_ready`=0 during reset and 1 on the first cycle after; all other outputs 0.
- Reset mid-operation aborts the request: no response and no further writes. The register files reset on the same `reset`.
- Back-to-back: a new request can be accepted on the cycle after RESP.

## Configuration
- **`ALLOC_BEST_FIT_EN` defined:** allocate scan starts at s=c. The lowest eligible region is then the smallest region that fits.
- **Not defined:** first fit, s=0 for all requests.
- Free always uses s=0 in both builds.

## Test plan
- After reset, alloc size 3, reg 2 → region 1, `resp_addr`=0x02, ok=1. Response at cycle 5 (first-fit) or 4 (best-fit). `st_a`=1, `st_wd`=0x3F, map[2]=0x02.
- Alloc size 2, reg 1 → region 0, addr 0x00, cycle 4. Then alloc size 64 → region 5, addr 0x3E; cycle 9 (first-fit) or 4 (best-fit).
- Alloc size 0 and size 65 → ok=0, addr 0 at cycle 2, no write strobes.
- Alloc size 3, reg 2, then free reg 2 → ok=1, addr 0x02, status[1]=0x3C, map[2]=0xFF. A second free of reg 2 → ok=0 at cycle 8.
- Six allocs of size 2 fill regions 0–5 → the seventh returns ok=0 at cycle 8 (first-fit).
- Assert reset during the SCAN of an allocation → no `resp_valid`, no writes; `req_ready`=1 on the cycle after reset deasserts.
